cordic_share_arb: RTL
=====================

CORDIC_SHARE_ARB -- requirements
Module: cordic_share_arb

Interface
REQ-001 Parameter WIDTH, 16, width of X/Y operands and of amplitude/theta results.
REQ-002 Parameter LAT, 17, fixed cycles from cor_req sampled high to matching cor_ack high.
REQ-003 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  grant enable; low blocks new grants, in-flight work still drains.
REQ-005 chN_valid  input  1  channel N (N=0,1) has an operand pair.
REQ-006 chN_ready  output  1  operand pair accepted this cycle.
REQ-007 chN_x, chN_y  input  WIDTH  signed operands of channel N.
REQ-008 cor_req  output  1  issue strobe to the shared CORDIC arctan pipeline.
REQ-009 cor_x, cor_y  output  WIDTH  signed operands to the CORDIC.
REQ-010 cor_ack, cor_amp, cor_theta  input  1/WIDTH/WIDTH  CORDIC completion strobe and results.
REQ-011 res_valid0, res_valid1  output  1  one-cycle result strobe for channel 0/1.
REQ-012 res_amp, res_theta  output  WIDTH  shared result bus, valid when either res_validN high.
REQ-013 busy  output  1  high while any issue is pending or any tag is in flight.
REQ-014 tag_err  output  1  sticky protocol error flag.

Function
REQ-015 Arbitration SHALL be round-robin: if both chN_valid are high with en high, the channel not granted last wins; if one is valid, it wins.
REQ-016 After reset the last-granted pointer SHALL equal channel 1, so channel 0 wins the first tie.
REQ-017 chN_ready SHALL be combinational, high only for the winner, at most one ready per cycle, and never high while en is low.
REQ-018 An accept (valid and ready in cycle n) SHALL drive cor_req=1 with registered cor_x/cor_y in cycle n+1; cor_req SHALL be 0 in cycles with no accept in the preceding cycle.
REQ-019 Back-to-back accepts SHALL produce cor_req high on consecutive cycles (throughput 1 per cycle).
REQ-020 Each issue SHALL push a tag {valid, channel} into a LAT-deep shift register advancing every cycle; a cycle without issue SHALL push valid=0.
REQ-021 When the tag reaching the end is valid and cor_ack is high, the block SHALL register cor_amp/cor_theta onto res_amp/res_theta and pulse res_validN for the tagged channel in the next cycle.
REQ-022 End-to-end latency SHALL be: accept in cycle n -> res_validN high in cycle n+LAT+2 (n+19 by default).
REQ-023 Results SHALL leave in issue order; res_valid0 and res_valid1 SHALL never be high together.
REQ-024 cor_ack high with an invalid end tag, or a valid end tag without cor_ack, SHALL set tag_err and produce no res_validN pulse for that cycle.
REQ-025 res_amp/res_theta SHALL hold their last value when no result is delivered.
REQ-026 busy SHALL be the OR of cor_req and all tag valid bits.
REQ-027 Deasserting en mid-stream SHALL only stop new grants; all in-flight tags SHALL still deliver.

Reset
REQ-028 On rst_n low all outputs SHALL be 0 (chN_ready, cor_req, cor_x, cor_y, res_validN, res_amp, res_theta, busy, tag_err), all tags invalid, and the pointer set to channel 1.
REQ-029 Reset mid-operation SHALL discard in-flight tags; no result SHALL be delivered for work accepted before reset.

Configuration
REQ-030 With macro CORDIC_ARB_STATS_EN defined, ports gnt_cnt0 and gnt_cnt1 (output, 16-bit) SHALL count accepts per channel, saturate at 16'hFFFF and reset to 0.
REQ-031 Without CORDIC_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then ch0 only, x=3 y=4 with model LAT=17 -> cor_req in cycle n+1 with cor_x=3 cor_y=4, res_valid0 in cycle n+19 with the model's amp/theta.
REQ-033 Both channels valid for 6 cycles -> grants 0,1,0,1,0,1; results return as ch0,ch1 alternating in the same order.
REQ-034 Drop en after 3 accepts while valids stay high -> ready stays low, exactly 3 results are delivered, busy falls one cycle after the last tag leaves.
REQ-035 Model injects a spurious cor_ack with no tag in flight -> tag_err=1 and stays 1, no res_validN pulse.
REQ-036 Assert rst_n low with 5 tags in flight -> all outputs 0 and no res_validN pulse afterwards for those 5 tags.
REQ-037 With CORDIC_ARB_STATS_EN, 70000 ch0 accepts -> gnt_cnt0=16'hFFFF and gnt_cnt1=0.

Source files
------------

// File: rtl/cordic_share_arb_if.sv
// Handshake and data bundle for the shared-CORDIC arbiter. It carries the two
// operand channels, the issue/completion bus to the CORDIC pipeline, and the
// shared result bus. The slave modport is the arbiter's view. The master
// modport is the view of the environment that drives operands and hosts the
// CORDIC.
interface cordic_share_arb_if #(
  parameter int WIDTH = 16
);
  logic             ch0_valid;
  logic             ch0_ready;
  logic [WIDTH-1:0] ch0_x;
  logic [WIDTH-1:0] ch0_y;

  logic             ch1_valid;
  logic             ch1_ready;
  logic [WIDTH-1:0] ch1_x;
  logic [WIDTH-1:0] ch1_y;

  logic             cor_req;
  logic [WIDTH-1:0] cor_x;
  logic [WIDTH-1:0] cor_y;
  logic             cor_ack;
  logic [WIDTH-1:0] cor_amp;
  logic [WIDTH-1:0] cor_theta;

  logic             res_valid0;
  logic             res_valid1;
  logic [WIDTH-1:0] res_amp;
  logic [WIDTH-1:0] res_theta;

  modport slave (
    input  ch0_valid, ch0_x, ch0_y,
    input  ch1_valid, ch1_x, ch1_y,
    input  cor_ack, cor_amp, cor_theta,
    output ch0_ready, ch1_ready,
    output cor_req, cor_x, cor_y,
    output res_valid0, res_valid1, res_amp, res_theta
  );

  modport master (
    output ch0_valid, ch0_x, ch0_y,
    output ch1_valid, ch1_x, ch1_y,
    output cor_ack, cor_amp, cor_theta,
    input  ch0_ready, ch1_ready,
    input  cor_req, cor_x, cor_y,
    input  res_valid0, res_valid1, res_amp, res_theta
  );
endinterface

// File: rtl/cordic_share_arb.sv
// Two-channel round-robin front end for one shared, fixed-latency CORDIC
// arctan pipeline.
// - Each accepted operand pair is issued one cycle later on cor_req/cor_x/cor_y.
// - A {valid, channel} tag is pushed into a LAT-deep shift register. The tag
//   reaches the end of the register in the same cycle the CORDIC returns
//   cor_ack.
// - Matching results are registered onto the shared result bus with a
//   per-channel strobe.
// - Any disagreement between the end tag and cor_ack sets a sticky tag_err.
// Optional feature: define CORDIC_ARB_STATS_EN to add the saturating 16-bit
// accept counters on ports gnt_cnt0/gnt_cnt1.
module cordic_share_arb #(
  parameter int WIDTH = 16,
  parameter int LAT   = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  cordic_share_arb_if.slave  bus,
  output logic               busy,
  output logic               tag_err
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [15:0]        gnt_cnt0,
  output logic [15:0]        gnt_cnt1
`endif
);

  // arbitration
  logic gnt0;
  logic gnt1;
  logic accept;
  logic last_d, last_q;

  // issue stage
  logic             cor_req_d, cor_req_q;
  logic             cor_ch_d, cor_ch_q;
  logic [WIDTH-1:0] cor_x_d, cor_x_q;
  logic [WIDTH-1:0] cor_y_d, cor_y_q;

  // in-flight tag pipeline, index LAT-1 lines up with cor_ack
  logic [LAT-1:0] tag_v_d, tag_v_q;
  logic [LAT-1:0] tag_ch_d, tag_ch_q;
  logic           end_v;
  logic           end_ch;
  logic           deliver;

  // result stage
  logic             res_valid0_d, res_valid0_q;
  logic             res_valid1_d, res_valid1_q;
  logic [WIDTH-1:0] res_amp_d, res_amp_q;
  logic [WIDTH-1:0] res_theta_d, res_theta_q;
  logic             tag_err_d, tag_err_q;

  // Round-robin grant: on a tie the channel not granted last wins. Gating
  // with rst_n keeps ready low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && en) begin
      if (bus.ch0_valid && bus.ch1_valid) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else if (bus.ch0_valid) begin
        gnt0 = 1'b1;
      end else if (bus.ch1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept        = gnt0 | gnt1;
  assign bus.ch0_ready = gnt0;
  assign bus.ch1_ready = gnt1;

  // Next-state for pointer, issue register and tag pipeline.
  always_comb begin
    last_d    = last_q;
    cor_req_d = accept;
    cor_ch_d  = gnt1;
    cor_x_d   = cor_x_q;
    cor_y_d   = cor_y_q;
    if (gnt0) begin
      last_d  = 1'b0;
      cor_x_d = bus.ch0_x;
      cor_y_d = bus.ch0_y;
    end else if (gnt1) begin
      last_d  = 1'b1;
      cor_x_d = bus.ch1_x;
      cor_y_d = bus.ch1_y;
    end
    // an issue cycle pushes a valid tag, any other cycle pushes a bubble
    tag_v_d  = {tag_v_q[LAT-2:0], cor_req_q};
    tag_ch_d = {tag_ch_q[LAT-2:0], cor_ch_q};
  end

  assign end_v   = tag_v_q[LAT-1];
  assign end_ch  = tag_ch_q[LAT-1];
  assign deliver = end_v & bus.cor_ack;

  // Result capture and sticky protocol check. The result bus holds between
  // deliveries. An ack with no tag, or a tag with no ack, delivers nothing.
  always_comb begin
    res_valid0_d = deliver & ~end_ch;
    res_valid1_d = deliver & end_ch;
    res_amp_d    = res_amp_q;
    res_theta_d  = res_theta_q;
    if (deliver) begin
      res_amp_d   = bus.cor_amp;
      res_theta_d = bus.cor_theta;
    end
    tag_err_d = tag_err_q | (end_v ^ bus.cor_ack);
  end

  // State registers; reset drops all in-flight tags and points at channel 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      cor_req_q    <= 1'b0;
      cor_ch_q     <= 1'b0;
      cor_x_q      <= '0;
      cor_y_q      <= '0;
      tag_v_q      <= '0;
      tag_ch_q     <= '0;
      res_valid0_q <= 1'b0;
      res_valid1_q <= 1'b0;
      res_amp_q    <= '0;
      res_theta_q  <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      last_q       <= last_d;
      cor_req_q    <= cor_req_d;
      cor_ch_q     <= cor_ch_d;
      cor_x_q      <= cor_x_d;
      cor_y_q      <= cor_y_d;
      tag_v_q      <= tag_v_d;
      tag_ch_q     <= tag_ch_d;
      res_valid0_q <= res_valid0_d;
      res_valid1_q <= res_valid1_d;
      res_amp_q    <= res_amp_d;
      res_theta_q  <= res_theta_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign bus.cor_req    = cor_req_q;
  assign bus.cor_x      = cor_x_q;
  assign bus.cor_y      = cor_y_q;
  assign bus.res_valid0 = res_valid0_q;
  assign bus.res_valid1 = res_valid1_q;
  assign bus.res_amp    = res_amp_q;
  assign bus.res_theta  = res_theta_q;
  assign tag_err        = tag_err_q;
  assign busy           = cor_req_q | (|tag_v_q);

`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] gnt_cnt0_d, gnt_cnt0_q;
  logic [15:0] gnt_cnt1_d, gnt_cnt1_q;

  // Per-channel accept counters that stick at all-ones.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (gnt0 && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (gnt1 && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule
